mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between the hart's instruction-fetch requester (IF) and its
//  load/store requester (DM). Replaces the separate combinational imem/dmem ports with a
//  valid/ready request side and a registered, variable-latency response side.
//  One transaction is outstanding at a time. DM has priority; a starvation counter guarantees IF progress.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive DM grants with IF pending before IF is forced (1..15)
//  TIMEOUT       64  max cycles in WAIT before an error response (2..1023)
// PORTS
//  i_clk           in   1   clock, rising edge
//  i_rst_n         in   1   asynchronous active-low reset
//  i_if_valid      in   1   IF fetch request
//  o_if_ready      out  1   IF request accepted this cycle
//  i_if_addr       in   32  fetch address, must be word aligned
//  o_if_rsp_valid  out  1   one-cycle pulse: IF response
//  o_if_rsp_rdata  out  32  fetched word (0 on error)
//  o_if_rsp_err    out  1   misaligned or timed-out fetch
//  i_dm_valid      in   1   DM request
//  o_dm_ready      out  1   DM request accepted this cycle
//  i_dm_addr       in   32  word-aligned data address
//  i_dm_ren        in   1   load
//  i_dm_wen        in   1   store
//  i_dm_wdata      in   32  store data, already lane-shifted
//  i_dm_mask       in   4   byte-lane mask
//  o_dm_rsp_valid  out  1   one-cycle pulse: DM response (loads and stores)
//  o_dm_rsp_rdata  out  32  load word (0 for stores/errors)
//  o_dm_rsp_err    out  1   illegal, misaligned or timed-out access
//  o_mem_req       out  1   memory request valid
//  i_mem_ready     in   1   memory accepted request
//  o_mem_addr      out  32  registered request address
//  o_mem_ren       out  1   read; IF always reads, mask 4'b1111
//  o_mem_wen       out  1   write
//  o_mem_wdata     out  32  write data
//  o_mem_mask      out  4   byte mask
//  i_mem_valid     in   1   response valid (reads and writes)
//  i_mem_rdata     in   32  read data
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE, starve cnt 0, timeout cnt 0.
//   All outputs 0 while reset is asserted and after reset until a request is granted.
//  States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on a locally detected error.
//  IDLE: ready is asserted combinationally to exactly one requester.
//   The granted requester is DM if i_dm_valid and not (i_if_valid and starve==STARVE_LIMIT); otherwise IF.
//   A request is accepted when valid & ready; the payload and owner are latched at that edge.
//  Starve counter: +1 on a DM grant while i_if_valid=1; cleared on any IF grant; saturates at STARVE_LIMIT.
//  Local errors are decided at accept and are never issued to memory:
//   - DM with ren&wen;
//   - DM with !ren&!wen;
//   - DM addr[1:0]!=0;
//   - IF addr[1:0]!=0.
//   Each one goes directly to RESP with err=1.
//  ISSUE: o_mem_req=1 with stable payload until i_mem_ready=1, then WAIT. There is no timeout in ISSUE.
//  WAIT: the timeout counter increments each cycle.
//   On i_mem_valid, rdata is captured (forced to 0 for writes) and the state goes to RESP.
//   If the counter reaches TIMEOUT-1 with no i_mem_valid, the state goes to RESP with err=1 and rdata=0.
//   i_mem_valid arriving in that same cycle wins; no error is raised.
//  RESP: the owner's rsp_valid is high for exactly one cycle; the response is registered and there is no backpressure.
//   Ready stays 0 for both requesters in RESP.
//  Stray i_mem_valid outside WAIT (e.g. a late reply after a timeout) is ignored.
//  Min latency for a legal access: accept at edge N, mem_req during N..N+1.
//   With zero-wait memory (ready and valid in the first possible cycle), rsp_valid is high in cycle N+3.
//   The lowest valid-to-valid throughput is one transaction per 4 cycles.
//  Reset mid-transaction aborts it: no response, o_mem_req drops immediately.
//  Requesters hold valid and payload stable until ready. Dropping valid before ready is legal and is treated as no request.
// TESTING
//  1. Single IF read at 0x100, memory returns 0xDEADBEEF 2 cycles after ready.
//     -> o_mem_req with addr 0x100, ren=1, mask 4'hF; one o_if_rsp_valid pulse, rdata 0xDEADBEEF, err=0.
//  2. IF and DM valid in the same cycle, DM sb to 0x2000 mask 4'b1000, wdata 0xAB000000.
//     -> DM granted first, mem_wen=1 mask 8; the IF fetch is issued after o_dm_rsp_valid.
//  3. IF held valid while DM issues 6 back-to-back loads, STARVE_LIMIT=4.
//     -> grant order DM,DM,DM,DM,IF,DM,DM.
//  4. DM request with ren=1,wen=1, and separately a DM load at 0x2002.
//     -> no o_mem_req; o_dm_rsp_err=1, rdata 0, two cycles after accept.
//  5. Load accepted, memory never asserts i_mem_valid, TIMEOUT=8.
//     -> o_dm_rsp_err pulse after 8 WAIT cycles.
//     A late i_mem_valid is ignored and the next request proceeds normally.
//  6. Assert i_rst_n=0 asynchronously during WAIT.
//     -> all outputs 0 before the next clock edge and no response pulse; a fetch after release completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch (IF) and load/store (DM), one transaction in flight.
// Latency: accept -> rsp_valid 4 cycles with zero-wait memory; local errors respond 2 cycles after accept.
// Backpressure: ready only in IDLE, to one requester; memory stalls via i_mem_ready; responses are not stallable.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_valid,
  output logic        o_if_ready,
  input  logic [31:0] i_if_addr,
  output logic        o_if_rsp_valid,
  output logic [31:0] o_if_rsp_rdata,
  output logic        o_if_rsp_err,
  input  logic        i_dm_valid,
  output logic        o_dm_ready,
  input  logic [31:0] i_dm_addr,
  input  logic        i_dm_ren,
  input  logic        i_dm_wen,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_mask,
  output logic        o_dm_rsp_valid,
  output logic [31:0] o_dm_rsp_rdata,
  output logic        o_dm_rsp_err,
  output logic        o_mem_req,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [9:0] TCNT_LAST  = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        owner_dm;   // 1: DM owns the transaction in flight
  logic        cur_wen;    // write in flight: read data is forced to 0
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  starve;
  logic [9:0]  tcnt;
  logic        grant_dm;
  logic        dm_bad;
  logic        if_bad;

  // Grant selection and local error decode; ready is masked during reset so nothing leaks out.
  always_comb begin
    grant_dm   = i_dm_valid && !(i_if_valid && (starve == STARVE_MAX));
    dm_bad     = (i_dm_ren == i_dm_wen) || (i_dm_addr[1:0] != 2'b00);
    if_bad     = (i_if_addr[1:0] != 2'b00);
    o_dm_ready = i_rst_n && (state == IDLE) && grant_dm;
    o_if_ready = i_rst_n && (state == IDLE) && !grant_dm && i_if_valid;
  end

  // Transaction FSM with registered memory-side and response-side outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      owner_dm       <= 1'b0;
      cur_wen        <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= 32'h0;
      starve         <= 4'd0;
      tcnt           <= 10'd0;
      o_mem_req      <= 1'b0;
      o_mem_addr     <= 32'h0;
      o_mem_ren      <= 1'b0;
      o_mem_wen      <= 1'b0;
      o_mem_wdata    <= 32'h0;
      o_mem_mask     <= 4'h0;
      o_if_rsp_valid <= 1'b0;
      o_if_rsp_rdata <= 32'h0;
      o_if_rsp_err   <= 1'b0;
      o_dm_rsp_valid <= 1'b0;
      o_dm_rsp_rdata <= 32'h0;
      o_dm_rsp_err   <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses; cleared unless RESP sets them below.
      o_if_rsp_valid <= 1'b0;
      o_if_rsp_rdata <= 32'h0;
      o_if_rsp_err   <= 1'b0;
      o_dm_rsp_valid <= 1'b0;
      o_dm_rsp_rdata <= 32'h0;
      o_dm_rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (o_dm_ready) begin
            owner_dm <= 1'b1;
            cur_wen  <= i_dm_wen;
            if (i_if_valid && (starve != STARVE_MAX)) starve <= starve + 4'd1;
            if (dm_bad) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              state     <= RESP;
            end else begin
              rsp_err     <= 1'b0;
              rsp_rdata   <= 32'h0;
              o_mem_req   <= 1'b1;
              o_mem_addr  <= i_dm_addr;
              o_mem_ren   <= i_dm_ren;
              o_mem_wen   <= i_dm_wen;
              o_mem_wdata <= i_dm_wdata;
              o_mem_mask  <= i_dm_mask;
              state       <= ISSUE;
            end
          end else if (o_if_ready) begin
            owner_dm <= 1'b0;
            cur_wen  <= 1'b0;
            starve   <= 4'd0;
            if (if_bad) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              state     <= RESP;
            end else begin
              rsp_err     <= 1'b0;
              rsp_rdata   <= 32'h0;
              o_mem_req   <= 1'b1;
              o_mem_addr  <= i_if_addr;
              o_mem_ren   <= 1'b1;
              o_mem_wen   <= 1'b0;
              o_mem_wdata <= 32'h0;
              o_mem_mask  <= 4'hF;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (i_mem_ready) begin
            o_mem_req <= 1'b0;
            tcnt      <= 10'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A reply in the last allowed cycle still beats the timeout.
          if (i_mem_valid) begin
            rsp_rdata <= cur_wen ? 32'h0 : i_mem_rdata;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else if (tcnt == TCNT_LAST) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            tcnt <= tcnt + 10'd1;
          end
        end
        RESP: begin
          if (owner_dm) begin
            o_dm_rsp_valid <= 1'b1;
            o_dm_rsp_rdata <= rsp_rdata;
            o_dm_rsp_err   <= rsp_err;
          end else begin
            o_if_rsp_valid <= 1'b1;
            o_if_rsp_rdata <= rsp_rdata;
            o_if_rsp_err   <= rsp_err;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
